// File: rtl/ctl_setup_rx.sv
// Receive side of the control pipe-0 path: captures the 8-byte SETUP payload,
// decodes the standard request fields and sequences the PIPE0 select/start handshake.
module ctl_setup_rx #(
    parameter int ACCEPT_TIMEOUT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    input  logic        s_tlast_i,
    input  logic [7:0]  s_tdata_i,
    input  logic        s_terror_i,
    output logic        select_o,
    output logic        start_o,
    input  logic        accept_i,
    input  logic        error_i,
    input  logic        done_i,
    input  logic        status_i,
    output logic [7:0]  req_type_o,
    output logic [7:0]  req_args_o,
    output logic [15:0] req_value_o,
    output logic [15:0] req_index_o,
    output logic [15:0] req_length_o,
    output logic        dir_in_o,
    output logic        stall_o,
    output logic        data_done_o,
    output logic        bad_setup_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_ACTIVE, S_STALL
    } state_t;

    localparam logic [3:0] TMO = 4'(ACCEPT_TIMEOUT);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       tmr_q, tmr_d;
    logic [6:0][7:0]  sh_q, sh_d;
    logic [63:0]      req_q, req_d;
    logic             data_done_q, data_done_d;
    logic             bad_setup_q, bad_setup_d;

    logic first_beat, last_beat, pkt_ok;

    assign first_beat = s_tvalid_i && (cnt_q == 4'd0);
    assign last_beat  = s_tvalid_i && s_tlast_i;
    // A well-formed end can only be the 8th byte; one landing in ACTIVE means
    // the packet started without an abort and is treated as malformed.
    assign pkt_ok     = last_beat && (cnt_q == 4'd7) && !s_terror_i && (state_q != S_ACTIVE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_IDLE;
            S_START:  state_d = S_WAIT;
            S_WAIT: begin
                if (error_i)                      state_d = S_STALL;
                else if (accept_i)                state_d = S_ACTIVE;
                else if ((tmr_q + 4'd1) == TMO)   state_d = S_STALL;
            end
            S_ACTIVE: if (status_i) state_d = S_IDLE;
            S_STALL:  state_d = S_STALL;
            default:  state_d = S_IDLE;
        endcase
        if (first_beat) state_d = S_IDLE;
        if (last_beat)  state_d = pkt_ok ? S_START : S_IDLE;
    end

    always_comb begin
        select_o = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_ACTIVE);
        start_o  = (state_q == S_START);
        stall_o  = (state_q == S_STALL);
    end

    // Capture path: the 8th byte bypasses the shadow so fields land with start_o.
    always_comb begin
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        req_d       = req_q;
        bad_setup_d = 1'b0;
        if (s_tvalid_i) begin
            for (int i = 0; i < 7; i++)
                if (cnt_q == 4'(i)) sh_d[i] = s_tdata_i;
            if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
            if (s_tlast_i) begin
                cnt_d = 4'd0;
                if (pkt_ok) req_d = {s_tdata_i, sh_q};
                else        bad_setup_d = 1'b1;
            end
        end
    end

    always_comb begin
        tmr_d       = tmr_q;
        data_done_d = data_done_q;
        if (state_q == S_START) begin
            tmr_d       = 4'd0;
            data_done_d = 1'b0;
        end else if (state_q == S_WAIT) begin
            tmr_d = tmr_q + 4'd1;
        end
        if (state_q == S_ACTIVE && done_i) data_done_d = 1'b1;
        if (first_beat && state_q != S_IDLE) data_done_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q       <= 4'd0;
            tmr_q       <= 4'd0;
            sh_q        <= '0;
            req_q       <= '0;
            data_done_q <= 1'b0;
            bad_setup_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            sh_q        <= sh_d;
            req_q       <= req_d;
            data_done_q <= data_done_d;
            bad_setup_q <= bad_setup_d;
        end
    end

    assign s_tready_o   = 1'b1;
    assign req_type_o   = req_q[7:0];
    assign req_args_o   = req_q[15:8];
    assign req_value_o  = req_q[31:16];
    assign req_index_o  = req_q[47:32];
    assign req_length_o = req_q[63:48];
    assign dir_in_o     = req_q[7];
    assign data_done_o  = data_done_q;
    assign bad_setup_o  = bad_setup_q;

endmodule

// File: tb/tb_ctl_setup_rx.sv
// Bench for ctl_setup_rx: a packet table checked through a response scoreboard,
// plus hand sequences for the PIPE0 handshake, stall, abort and reset corners.
module tb_ctl_setup_rx;

    logic        clock = 1'b0;
    logic        reset;
    logic        s_tvalid_i, s_tlast_i, s_terror_i;
    logic [7:0]  s_tdata_i;
    logic        s_tready_o;
    logic        select_o, start_o, accept_i, error_i, done_i, status_i;
    logic [7:0]  req_type_o, req_args_o;
    logic [15:0] req_value_o, req_index_o, req_length_o;
    logic        dir_in_o, stall_o, data_done_o, bad_setup_o;

    ctl_setup_rx #(.ACCEPT_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i),
        .s_tdata_i(s_tdata_i), .s_terror_i(s_terror_i),
        .select_o(select_o), .start_o(start_o), .accept_i(accept_i), .error_i(error_i),
        .done_i(done_i), .status_i(status_i),
        .req_type_o(req_type_o), .req_args_o(req_args_o), .req_value_o(req_value_o),
        .req_index_o(req_index_o), .req_length_o(req_length_o), .dir_in_o(dir_in_o),
        .stall_o(stall_o), .data_done_o(data_done_o), .bad_setup_o(bad_setup_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  b [10];
        int          n;
        bit          terr;
        bit          ok;
        logic [63:0] req;   // {length, index, value, args, type}
    } vec_t;

    typedef struct {
        bit          ok;
        logic [63:0] req;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl [9];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [63:0] REQ_A = 64'h0012_0000_0100_0680; // GET_DESCRIPTOR
    localparam logic [63:0] REQ_B = 64'h0000_0000_002A_0500; // SET_ADDRESS 42
    localparam logic [63:0] REQ_C = 64'h0000_0000_0001_0900; // SET_CONFIGURATION 1
    localparam logic [63:0] REQ_D = 64'h0002_0000_0000_0080; // GET_STATUS

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8, b9,
                                input int n, input bit terr, input bit ok, input logic [63:0] req);
        vec_t v;
        v.b    = '{b0, b1, b2, b3, b4, b5, b6, b7, b8, b9};
        v.n    = n;
        v.terr = terr;
        v.ok   = ok;
        v.req  = req;
        return v;
    endfunction

    // Drives one packet starting at the next falling edge; returns on the falling
    // edge after the last beat, i.e. the cycle a good packet shows start_o.
    task automatic send(input vec_t v, input bit chk_abort);
        exp_t e;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clock);
            if (chk_abort && i == 1) begin
                chk("abort_select", select_o, 0);
                chk("abort_stall", stall_o, 0);
                chk("abort_done", data_done_o, 0);
            end
            s_tvalid_i  = 1'b1;
            s_tdata_i   = v.b[i];
            s_tlast_i   = (i == v.n - 1);
            s_terror_i  = v.terr && (i == v.n - 1);
            if (i == v.n - 1) begin
                e.ok  = v.ok;
                e.req = v.req;
                sb.push_back(e);
            end
        end
        @(negedge clock);
        s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_terror_i = 1'b0; s_tdata_i = 8'h00;
    endtask

    // Every start_o or bad_setup_o cycle must match the oldest pending packet.
    always @(negedge clock) begin
        if (!reset && (start_o || bad_setup_o)) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_resp: start=%0b bad=%0b with no packet pending", start_o, bad_setup_o);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_start", start_o, mon_e.ok);
                chk("resp_bad", bad_setup_o, !mon_e.ok);
                chk("resp_select", select_o, mon_e.ok);
                chk("resp_req", {req_length_o, req_index_o, req_value_o, req_args_o, req_type_o}, mon_e.req);
                chk("resp_dir", dir_in_o, mon_e.req[7]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s_tvalid_i = 0; s_tlast_i = 0; s_terror_i = 0; s_tdata_i = 0;
        accept_i = 0; error_i = 0; done_i = 0; status_i = 0;

        tbl[0] = mk(8'h80,8'h06,8'h00,8'h01,8'h00,8'h00,8'h12,8'h00,8'h00,8'h00, 8, 0, 1, REQ_A);
        tbl[1] = mk(8'h80,8'h06,8'h00,8'h02,8'h00,8'h00,8'h09,8'h00,8'h00,8'h00, 7, 0, 0, REQ_A);
        tbl[2] = mk(8'h00,8'h05,8'h2A,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 8, 0, 1, REQ_B);
        tbl[3] = mk(8'h80,8'h06,8'h00,8'h03,8'h00,8'h00,8'hFF,8'h00,8'h00,8'h00, 8, 1, 0, REQ_B);
        tbl[4] = mk(8'h81,8'h0A,8'h00,8'h00,8'h01,8'h00,8'h01,8'h00,8'hEE,8'hDD, 10, 0, 0, REQ_B);
        tbl[5] = mk(8'h80,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 1, 0, 0, REQ_B);
        tbl[6] = mk(8'h00,8'h09,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h77,8'h00, 9, 0, 0, REQ_B);
        tbl[7] = mk(8'h00,8'h09,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 8, 0, 1, REQ_C);
        tbl[8] = mk(8'h80,8'h00,8'h00,8'h00,8'h00,8'h00,8'h02,8'h00,8'h00,8'h00, 8, 0, 1, REQ_D);

        #3;
        chk("rst_tready", s_tready_o, 1);
        chk("rst_outs", {select_o, start_o, stall_o, data_done_o, bad_setup_o, dir_in_o}, 0);
        chk("rst_req", {req_length_o, req_index_o, req_value_o, req_args_o, req_type_o}, 0);
        @(negedge clock); reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send(tbl[i], 1'b0);
            repeat (8) @(negedge clock);
            chk("drain", sb.size(), 0);
        end

        // GET_DESCRIPTOR full handshake
        send(tbl[0], 1'b0);
        chk("gd_start", start_o, 1);
        chk("gd_select", select_o, 1);
        chk("gd_len", req_length_o, 16'h0012);
        @(negedge clock); accept_i = 1;
        @(negedge clock); accept_i = 0; done_i = 1;
        @(negedge clock); done_i = 0;
        chk("gd_done", data_done_o, 1);
        chk("gd_active_sel", select_o, 1);
        status_i = 1;
        @(negedge clock); status_i = 0;
        chk("gd_status_sel", select_o, 0);
        chk("gd_stall", stall_o, 0);

        // SET_ADDRESS
        send(tbl[2], 1'b0);
        chk("sa_value", req_value_o, 16'h002A);
        chk("sa_dir", dir_in_o, 0);
        @(negedge clock); accept_i = 1;
        @(negedge clock); accept_i = 0;
        chk("sa_stall_act", stall_o, 0);
        chk("sa_select", select_o, 1);
        status_i = 1;
        @(negedge clock); status_i = 0;
        chk("sa_idle_sel", select_o, 0);
        chk("sa_stall_idle", stall_o, 0);

        // unsupported request -> STALL, status ignored, cleared by next SETUP
        send(tbl[0], 1'b0);
        @(negedge clock); error_i = 1; accept_i = 1;
        @(negedge clock); error_i = 0; accept_i = 0;
        chk("err_stall", stall_o, 1);
        chk("err_select", select_o, 0);
        status_i = 1;
        @(negedge clock); status_i = 0;
        chk("err_stall_hold", stall_o, 1);
        send(tbl[2], 1'b1);

        // no accept/error: stall after exactly 4 WAIT cycles
        send(tbl[7], 1'b0);
        repeat (4) @(negedge clock);
        chk("tmo_before", stall_o, 0);
        chk("tmo_sel_before", select_o, 1);
        @(negedge clock);
        chk("tmo_stall", stall_o, 1);
        chk("tmo_select", select_o, 0);

        // abort during ACTIVE with data_done set
        send(tbl[0], 1'b0);
        @(negedge clock); accept_i = 1;
        @(negedge clock); accept_i = 0; done_i = 1;
        @(negedge clock); done_i = 0;
        chk("ab_done_set", data_done_o, 1);
        send(tbl[8], 1'b1);
        chk("ab_restart", start_o, 1);
        chk("ab_new_req", req_length_o, 16'h0002);

        // reset mid-packet at byte 4
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            s_tvalid_i = 1; s_tdata_i = tbl[2].b[i]; s_tlast_i = 0;
        end
        @(posedge clock); #2; reset = 1'b1; s_tvalid_i = 0;
        #1;
        chk("rm_outs", {select_o, start_o, stall_o, data_done_o, bad_setup_o}, 0);
        chk("rm_req", {req_length_o, req_index_o, req_value_o, req_args_o, req_type_o}, 0);
        @(negedge clock); reset = 1'b0;
        send(tbl[0], 1'b0);
        chk("rm_decode", req_value_o, 16'h0100);

        // reset while ACTIVE
        @(negedge clock); accept_i = 1;
        @(negedge clock); accept_i = 0;
        chk("ra_active", select_o, 1);
        #2; reset = 1'b1;
        #1;
        chk("ra_outs", {select_o, start_o, stall_o, data_done_o, bad_setup_o}, 0);
        chk("ra_req", {req_length_o, req_index_o, req_value_o, req_args_o, req_type_o}, 0);
        @(negedge clock); reset = 1'b0;
        send(tbl[7], 1'b0);
        chk("ra_decode", req_args_o, 8'h09);

        repeat (6) @(negedge clock);
        chk("final_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
